// File: rtl/move_input_conditioner.sv
// move_input_conditioner: synchronises and debounces four active-low buttons and divides a frame strobe into an update pulse.
// Define MOVE_OPPOSITE_MASK_EN to release both members of an opposing pair while both are held.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18,
  parameter int V_TRIGGER = 480,
  parameter int UPDATE_DIV = 1,
  parameter int DIV_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       update
);
  logic [3:0] raw, s1_q, s2_q, stable_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [DIV_W-1:0] div_q;
  logic match, match_q, strobe, update_q;
  assign raw = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
      stable_q <= '1;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == stable_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end
  // Edge-detect the match so a slow pixel clock still yields one strobe per frame.
  assign match = (xCount == 10'd0) && (yCount == 10'(V_TRIGGER));
  assign strobe = match & ~match_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      div_q <= '0;
      update_q <= 1'b0;
    end else begin
      match_q <= match;
      update_q <= strobe && (div_q == DIV_W'(UPDATE_DIV - 1));
      if (strobe) div_q <= (div_q == DIV_W'(UPDATE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
  end
  assign update = update_q;
`ifdef MOVE_OPPOSITE_MASK_EN
  logic ud_both, lr_both;
  assign ud_both = ~(stable_q[3] | stable_q[2]);
  assign lr_both = ~(stable_q[1] | stable_q[0]);
  assign {up, down, left, right} = stable_q | {ud_both, ud_both, lr_both, lr_both};
`else
  assign {up, down, left, right} = stable_q;
`endif
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed and random checks of debounce and update division against a history-based model.
module tb_move_input_conditioner;
  localparam int DB = 4;
  localparam int DIV3 = 3;
  logic clk = 1'b0;
  logic rst;
  logic bu, bd, bl, br;
  logic [9:0] xCount, yCount;
  logic up3, down3, left3, right3, upd3;
  logic up1, down1, left1, right1, upd1;
  int checks = 0;
  int errors = 0;
  logic [3:0] s1m, s2m, stm;
  logic [15:0] hist [4];
  logic mprev, eu1, eu3;
  int f3;
  int p1, p3;

  always #5 clk = ~clk;

  move_input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3), .V_TRIGGER(480), .UPDATE_DIV(DIV3), .DIV_W(2)) u3 (
    .clk(clk), .rst(rst), .btn_up_n(bu), .btn_down_n(bd), .btn_left_n(bl), .btn_right_n(br),
    .xCount(xCount), .yCount(yCount), .up(up3), .down(down3), .left(left3), .right(right3), .update(upd3));

  move_input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3), .V_TRIGGER(480), .UPDATE_DIV(1), .DIV_W(1)) u1 (
    .clk(clk), .rst(rst), .btn_up_n(bu), .btn_down_n(bd), .btn_left_n(bl), .btn_right_n(br),
    .xCount(xCount), .yCount(yCount), .up(up1), .down(down1), .left(left1), .right(right1), .update(upd1));

  function automatic logic [3:0] visible(input logic [3:0] s);
`ifdef MOVE_OPPOSITE_MASK_EN
    logic ud, lr;
    ud = ~s[3] & ~s[2];
    lr = ~s[1] & ~s[0];
    return s | {ud, ud, lr, lr};
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A button's level flips once its synchronised level has disagreed with it for DB consecutive edges.
  task automatic tick();
    logic m, st;
    @(posedge clk);
    if (rst) begin
      s1m = '1; s2m = '1; stm = '1;
      for (int b = 0; b < 4; b++) hist[b] = '1;
      mprev = 1'b0; eu1 = 1'b0; eu3 = 1'b0; f3 = 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        hist[b] = {hist[b][14:0], s2m[b]};
        if (hist[b][DB-1:0] == {DB{~stm[b]}}) stm[b] = ~stm[b];
      end
      s2m = s1m;
      s1m = {bu, bd, bl, br};
      m = (xCount == 10'd0) && (yCount == 10'd480);
      st = m && !mprev;
      eu1 = st;
      eu3 = st && ((f3 + 1) % DIV3 == 0);
      if (st) f3++;
      mprev = m;
    end
    #1;
    chk("dirs_div3", {28'd0, up3, down3, left3, right3}, {28'd0, visible(stm)});
    chk("dirs_div1", {28'd0, up1, down1, left1, right1}, {28'd0, visible(stm)});
    chk("update_div3", {31'd0, upd3}, {31'd0, eu3});
    chk("update_div1", {31'd0, upd1}, {31'd0, eu1});
  endtask

  task automatic settle();
    bu = 1'b1; bd = 1'b1; bl = 1'b1; br = 1'b1;
    repeat (8) tick();
  endtask

  task automatic frame(output int n1, output int n3);
    n1 = 0;
    n3 = 0;
    for (int y = 478; y <= 482; y++) begin
      yCount = 10'(y);
      xCount = (y == 480) ? 10'd0 : 10'd7;
      repeat ((y == 480) ? 2 : 1) begin
        tick();
        n1 += int'(upd1);
        n3 += int'(upd3);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bu = 1'b1; bd = 1'b1; bl = 1'b1; br = 1'b1;
    xCount = 10'd7; yCount = 10'd0;
    s1m = '1; s2m = '1; stm = '1; mprev = 1'b0; eu1 = 1'b0; eu3 = 1'b0; f3 = 0;
    for (int b = 0; b < 4; b++) hist[b] = '1;
    repeat (2) tick();
    chk("reset_dirs", {28'd0, up3, down3, left3, right3}, 32'hF);
    chk("reset_update", {31'd0, upd3}, 32'd0);
    rst = 1'b0;
    tick();
    bu = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("latency_up", {31'd0, up3}, (k < 6) ? 32'd1 : 32'd0);
      chk("latency_others", {29'd0, down3, left3, right3}, 32'h7);
    end
    settle();
    repeat (5) begin
      bl = 1'b0;
      repeat (3) begin
        tick();
        chk("bounce_left", {31'd0, left3}, 32'd1);
      end
      bl = 1'b1;
      tick();
      chk("bounce_left", {31'd0, left3}, 32'd1);
    end
    bl = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("bounce_hold", {31'd0, left3}, (k < 6) ? 32'd1 : 32'd0);
    end
    settle();
    for (int f = 1; f <= 7; f++) begin
      frame(p1, p3);
      chk("frame_div1", p1, 32'd1);
      chk("frame_div3", p3, (f % 3 == 0) ? 32'd1 : 32'd0);
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      frame(p1, p3);
      chk("post_reset_div3", p3, (f == 3) ? 32'd1 : 32'd0);
    end
    br = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      chk("reset_mid_right", {31'd0, right3}, 32'd1);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("reset_mid_after", {31'd0, right3}, (k < 6) ? 32'd1 : 32'd0);
    end
    settle();
    bu = 1'b0;
    bd = 1'b0;
    repeat (8) tick();
`ifdef MOVE_OPPOSITE_MASK_EN
    chk("mask_both", {30'd0, up3, down3}, 32'h3);
    bd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("mask_release_up", {31'd0, up3}, (k < 6) ? 32'd1 : 32'd0);
    end
`else
    chk("nomask_both", {30'd0, up3, down3}, 32'h0);
`endif
    settle();
    repeat (600) begin
      if ($urandom_range(7) == 0) bu = ~bu;
      if ($urandom_range(7) == 0) bd = ~bd;
      if ($urandom_range(7) == 0) bl = ~bl;
      if ($urandom_range(7) == 0) br = ~br;
      yCount = ($urandom_range(3) == 0) ? 10'd480 : 10'($urandom_range(479));
      xCount = ($urandom_range(1) == 0) ? 10'd0 : 10'd1;
      rst = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0;
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
